// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: master/slave counts, index widths and the
// AR forwarding state encoding.
package axi_ic_pkg;

    localparam int unsigned M         = 2;
    localparam int unsigned S         = 2;
    localparam int unsigned MST_IDX_W = $clog2(M);
    localparam int unsigned SLV_IDX_W = $clog2(S);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } ar_state_e;

endpackage

// File: rtl/outstanding_counter.sv
// Per-master count of accepted reads whose final R beat has not completed yet;
// saturates at MAX_COUNT and ignores spurious decrements at zero.
module outstanding_counter #(
    parameter int unsigned MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] r_count;

    // Coincident inc/dec cancel; each direction is clamped at its bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != CNT_W'(MAX_COUNT)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_full = (r_count == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/ar_forward.sv
// Forwards one granted AR request at a time from two masters to two slaves,
// pulsing the master's ARready once the slave has accepted the address.
module ar_forward
    import axi_ic_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH            = 32,
    parameter int unsigned ID_WIDTH              = 4,
    parameter int unsigned NUM_OUTSTANDING_TRANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  M0_ARgrant,
    input  logic                  M0_ARsel,
    input  logic                  M0_ARvalid,
    input  logic [ADDR_WIDTH-1:0] M0_ARaddr,
    input  logic [ID_WIDTH-1:0]   M0_ARid,
    output logic                  M0_ARready,
    output logic                  M0_ARfull,
    input  logic                  M0_Rdone,

    input  logic                  M1_ARgrant,
    input  logic                  M1_ARsel,
    input  logic                  M1_ARvalid,
    input  logic [ADDR_WIDTH-1:0] M1_ARaddr,
    input  logic [ID_WIDTH-1:0]   M1_ARid,
    output logic                  M1_ARready,
    output logic                  M1_ARfull,
    input  logic                  M1_Rdone,

    output logic                  S0_ARvalid,
    input  logic                  S0_ARready,
    output logic                  S1_ARvalid,
    input  logic                  S1_ARready,
    output logic [ADDR_WIDTH-1:0] S_ARaddr,
    output logic [ID_WIDTH:0]     S_ARid
);

    ar_state_e              r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ID_WIDTH:0]      r_id;
    logic [SLV_IDX_W-1:0]   r_sel;
    logic [MST_IDX_W-1:0]   r_mst;
    logic                   r_s0_valid;
    logic                   r_s1_valid;
    logic                   r_m0_ready;
    logic                   r_m1_ready;

    logic                   w_m0_full;
    logic                   w_m1_full;
    logic                   w_m0_req;
    logic                   w_m1_req;
    logic                   w_cap;
    logic [MST_IDX_W-1:0]   w_cap_mst;
    logic [SLV_IDX_W-1:0]   w_cap_sel;
    logic [ADDR_WIDTH-1:0]  w_cap_addr;
    logic [ID_WIDTH-1:0]    w_cap_id;
    logic                   w_hs;
    logic                   w_m0_inc;
    logic                   w_m1_inc;

    // Master 0 takes priority if the arbiter ever grants both at once.
    assign w_m0_req   = M0_ARgrant & M0_ARvalid & ~w_m0_full;
    assign w_m1_req   = M1_ARgrant & M1_ARvalid & ~w_m1_full;
    assign w_cap      = w_m0_req | w_m1_req;
    assign w_cap_mst  = w_m0_req ? '0 : MST_IDX_W'(1);
    assign w_cap_sel  = w_m0_req ? SLV_IDX_W'(M0_ARsel) : SLV_IDX_W'(M1_ARsel);
    assign w_cap_addr = w_m0_req ? M0_ARaddr : M1_ARaddr;
    assign w_cap_id   = w_m0_req ? M0_ARid : M1_ARid;

    assign w_hs     = (r_state == ST_SEND) &
                      ((r_sel == '0) ? S0_ARready : S1_ARready);
    assign w_m0_inc = w_hs & (r_mst == '0);
    assign w_m1_inc = w_hs & (r_mst == MST_IDX_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_id       <= '0;
            r_sel      <= '0;
            r_mst      <= '0;
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cap) begin
                        r_addr     <= w_cap_addr;
                        r_id       <= {w_cap_mst, w_cap_id};
                        r_sel      <= w_cap_sel;
                        r_mst      <= w_cap_mst;
                        r_s0_valid <= (w_cap_sel == '0);
                        r_s1_valid <= (w_cap_sel == SLV_IDX_W'(1));
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_s0_valid <= 1'b0;
                        r_s1_valid <= 1'b0;
                        r_m0_ready <= (r_mst == '0);
                        r_m1_ready <= (r_mst == MST_IDX_W'(1));
                        r_state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    outstanding_counter #(
        .MAX_COUNT (NUM_OUTSTANDING_TRANS)
    ) u_cnt_m0 (
        .clk    (clk),
        .rst_n  (rst),
        .i_inc  (w_m0_inc),
        .i_dec  (M0_Rdone),
        .o_full (w_m0_full)
    );

    outstanding_counter #(
        .MAX_COUNT (NUM_OUTSTANDING_TRANS)
    ) u_cnt_m1 (
        .clk    (clk),
        .rst_n  (rst),
        .i_inc  (w_m1_inc),
        .i_dec  (M1_Rdone),
        .o_full (w_m1_full)
    );

    assign S0_ARvalid = r_s0_valid;
    assign S1_ARvalid = r_s1_valid;
    assign S_ARaddr   = r_addr;
    assign S_ARid     = r_id;
    assign M0_ARready = r_m0_ready;
    assign M1_ARready = r_m1_ready;
    assign M0_ARfull  = w_m0_full;
    assign M1_ARfull  = w_m1_full;

endmodule

// File: doc/ar_forward.md
AR_FORWARD -- requirements
Module: ar_forward

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AR address width.
REQ-002 Parameter ID_WIDTH, default 4, master-side transaction ID width.
REQ-003 Parameter NUM_OUTSTANDING_TRANS, default 4, maximum accepted-but-uncompleted reads per master.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 M0_ARgrant / M1_ARgrant  input  1  arbiter grant for master n.
REQ-007 M0_ARsel / M1_ARsel  input  1  arbiter-decoded target slave for master n.
REQ-008 M0_ARvalid / M1_ARvalid  input  1  master n AR payload valid.
REQ-009 M0_ARaddr / M1_ARaddr  input  ADDR_WIDTH  master n read address.
REQ-010 M0_ARid / M1_ARid  input  ID_WIDTH  master n transaction ID.
REQ-011 M0_ARready / M1_ARready  output  1  one-cycle completion pulse to master n.
REQ-012 M0_ARfull / M1_ARfull  output  1  master n outstanding limit reached.
REQ-013 M0_Rdone / M1_Rdone  input  1  one-cycle pulse: master n final read beat (RLAST handshake) completed.
REQ-014 S0_ARvalid / S1_ARvalid  output  1  AR valid toward slave n.
REQ-015 S_ARaddr  output  ADDR_WIDTH  registered address, shared by both slaves.
REQ-016 S_ARid  output  ID_WIDTH+1  {master index, master ARid}, shared.
REQ-017 S0_ARready / S1_ARready  input  1  slave n accepts AR.

Function
REQ-018 FSM SHALL have states IDLE, SEND, ACK.
REQ-019 IDLE: on Mn_ARgrant=1, Mn_ARvalid=1 and Mn_ARfull=0, SHALL register addr, {n,id}, sel and master index; next state SEND.
REQ-020 If both grants are qualified in one cycle (arbiter violation), master 0 SHALL win; master 1 SHALL be ignored.
REQ-021 SEND: Sk_ARvalid SHALL be 1 only for k = latched sel; S_ARaddr/S_ARid SHALL hold stable until handshake.
REQ-022 SEND with Sk_ARready=1 SHALL complete the handshake; next state ACK.
REQ-023 ACK: latched master's Mn_ARready SHALL be 1 for exactly one cycle; next state IDLE.
REQ-024 Minimum latency: capture edge N, Sk_ARvalid high cycle N+1, Mn_ARready high cycle after slave handshake.
REQ-025 Grant or valid deassertion during SEND/ACK SHALL NOT abort the transfer.
REQ-026 Per-master outstanding count, width $clog2(NUM_OUTSTANDING_TRANS+1), SHALL increment on slave handshake and decrement on Mn_Rdone.
REQ-027 Simultaneous increment and decrement for one master SHALL leave its count unchanged.
REQ-028 Decrement at 0 SHALL be ignored; increment SHALL never exceed NUM_OUTSTANDING_TRANS.
REQ-029 Mn_ARfull SHALL be 1 iff count equals NUM_OUTSTANDING_TRANS (combinational from count).
REQ-030 S_ARaddr/S_ARid SHALL hold their last value outside SEND.

Reset
REQ-031 On rst=0: state IDLE; counts 0; all Sk_ARvalid, Mn_ARready, Mn_ARfull 0; S_ARaddr and S_ARid 0.
REQ-032 Reset assertion mid-SEND SHALL drop Sk_ARvalid immediately, with no ACK pulse.

Structure
REQ-033 Shared package axi_ic_pkg SHALL hold master count M=2, slave count S=2, and the IDLE/SEND/ACK state encoding.
REQ-034 Sub-module outstanding_counter (inc, dec, count, full) SHALL be instantiated once per master.

Verification
REQ-035 M0 grant+valid, addr 0x0000_1000, id 3, sel 1; S1_ARready on 2nd SEND cycle -> S1_ARvalid for 2 cycles, S_ARid=0x03, M0_ARready one pulse, M0 count 1.
REQ-036 M1 issues 4 reads, no Rdone -> M1_ARfull=1; 5th grant not captured; one M1_Rdone -> full clears, 5th proceeds.
REQ-037 M0 and M1 grants both high in IDLE -> only M0 captured, S_ARid[ID_WIDTH]=0.
REQ-038 M0 count 2, handshake and M0_Rdone same cycle -> count stays 2.
REQ-039 rst low in SEND -> Sk_ARvalid 0 asynchronously, no Mn_ARready, counts 0 after release.
REQ-040 Rdone at count 0 -> count stays 0, no underflow.
